// File: rtl/time_keeper_pkg.sv
// Shared types and constants for the digital clock timekeeping front end:
// adjust-mode encoding, segment codes and digit positions of adjustable fields.
package time_keeper_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        ADJ_HOUR = 2'd1,
        ADJ_MIN  = 2'd2,
        ADJ_SEC  = 2'd3
    } mode_t;

    localparam logic [7:0] SEG_DASH = 8'hBF;
    localparam logic [7:0] SEG_OFF  = 8'hFF;

    localparam logic [3:0] IDX_HOUR = 4'd0;
    localparam logic [3:0] IDX_MIN  = 4'd3;
    localparam logic [3:0] IDX_SEC  = 4'd6;

    // Active-low segments, bit7 = dp (kept off), bits[6:0] = gfedcba.
    function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    bcd_to_seg = 8'hC0;
            4'd1:    bcd_to_seg = 8'hF9;
            4'd2:    bcd_to_seg = 8'hA4;
            4'd3:    bcd_to_seg = 8'hB0;
            4'd4:    bcd_to_seg = 8'h99;
            4'd5:    bcd_to_seg = 8'h92;
            4'd6:    bcd_to_seg = 8'h82;
            4'd7:    bcd_to_seg = 8'hF8;
            4'd8:    bcd_to_seg = 8'h80;
            4'd9:    bcd_to_seg = 8'h90;
            default: bcd_to_seg = SEG_OFF;
        endcase
    endfunction

endpackage

// File: rtl/bcd_field_counter.sv
// Two-digit packed BCD counter running MIN_BCD..MAX_BCD; carry is raised on the
// wrapping increment only when the caller enables carry propagation.
module bcd_field_counter
    import time_keeper_pkg::*;
#(
    parameter logic [7:0] MIN_BCD = 8'h00,
    parameter logic [7:0] MAX_BCD = 8'h59,
    parameter logic [7:0] RST_BCD = 8'h00
) (
    input  logic       CP_1KHz,
    input  logic       _CR,
    input  logic       inc,
    input  logic       carry_en,
    output logic [7:0] value,
    output logic       carry
);

    logic at_max;

    assign at_max = (value == MAX_BCD);
    assign carry  = inc & carry_en & at_max;

    always_ff @(posedge CP_1KHz or negedge _CR) begin
        if (!_CR) begin
            value <= RST_BCD;
        end else if (inc) begin
            if (at_max)
                value <= MIN_BCD;
            else if (value[3:0] == 4'd9)
                value <= {value[7:4] + 4'd1, 4'd0};
            else
                value <= {value[7:4], value[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/time_keeper.sv
// Seconds prescaler, BCD h/m/s counters, two-key adjust FSM and registered
// segment image. Define TIME_KEEPER_12H_EN for 12-hour display with pm on digit-7 dp.
module time_keeper
    import time_keeper_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic        CP_1KHz,
    input  logic        _CR,
    input  logic        key_mode,
    input  logic        key_inc,
    output logic [63:0] display_time,
    output logic [3:0]  index,
    output logic        adjust,
    output logic        sec_tick
);

    localparam int          PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] TC = PW'(TICKS_PER_SEC - 1);

`ifdef TIME_KEEPER_12H_EN
    localparam logic [7:0]  HOUR_MIN = 8'h01;
    localparam logic [7:0]  HOUR_MAX = 8'h12;
    localparam logic [7:0]  HOUR_RST = 8'h12;
    localparam logic [63:0] DISP_RST = 64'hF9A4_BFC0_C0BF_C0C0;
`else
    localparam logic [7:0]  HOUR_MIN = 8'h00;
    localparam logic [7:0]  HOUR_MAX = 8'h23;
    localparam logic [7:0]  HOUR_RST = 8'h00;
    localparam logic [63:0] DISP_RST = 64'hC0C0_BFC0_C0BF_C0C0;
`endif

    mode_t         state, state_d;
    logic [PW-1:0] presc;
    logic          tick;
    logic          mode_cur, mode_prev, inc_cur, inc_prev;
    logic          mode_edge, inc_edge, adj_inc;
    logic          sec_inc, min_inc, hour_inc;
    logic          sec_carry, min_carry, hour_carry_unused;
    logic [7:0]    sec, min, hour;
    logic          adjust_d;
    logic [3:0]    index_d;
    logic          dp_n;

    // prev resets high so a key held through reset release is not an edge
    always_ff @(posedge CP_1KHz or negedge _CR) begin
        if (!_CR) begin
            mode_cur  <= 1'b1;
            mode_prev <= 1'b1;
            inc_cur   <= 1'b1;
            inc_prev  <= 1'b1;
        end else begin
            mode_cur  <= key_mode;
            mode_prev <= mode_cur;
            inc_cur   <= key_inc;
            inc_prev  <= inc_cur;
        end
    end

    assign mode_edge = mode_cur & ~mode_prev;
    assign inc_edge  = inc_cur & ~inc_prev;
    assign adj_inc   = inc_edge & ~mode_edge;

    assign tick     = (state == RUN) && (presc == TC);
    assign sec_tick = tick;

    always_ff @(posedge CP_1KHz or negedge _CR) begin
        if (!_CR)
            presc <= '0;
        else if (state != RUN || tick)
            presc <= '0;
        else
            presc <= presc + PW'(1);
    end

    always_comb begin
        state_d  = state;
        adjust_d = 1'b0;
        index_d  = IDX_HOUR;
        if (mode_edge) begin
            case (state)
                RUN:      state_d = ADJ_HOUR;
                ADJ_HOUR: state_d = ADJ_MIN;
                ADJ_MIN:  state_d = ADJ_SEC;
                default:  state_d = RUN;
            endcase
        end
        case (state_d)
            ADJ_HOUR: begin adjust_d = 1'b1; index_d = IDX_HOUR; end
            ADJ_MIN:  begin adjust_d = 1'b1; index_d = IDX_MIN;  end
            ADJ_SEC:  begin adjust_d = 1'b1; index_d = IDX_SEC;  end
            default:  begin adjust_d = 1'b0; index_d = IDX_HOUR; end
        endcase
    end

    always_ff @(posedge CP_1KHz or negedge _CR) begin
        if (!_CR) begin
            state  <= RUN;
            adjust <= 1'b0;
            index  <= IDX_HOUR;
        end else begin
            state  <= state_d;
            adjust <= adjust_d;
            index  <= index_d;
        end
    end

    // Carries only ripple on a real tick; adjust increments wrap in place.
    assign sec_inc  = tick | (adj_inc && state == ADJ_SEC);
    assign min_inc  = sec_carry | (adj_inc && state == ADJ_MIN);
    assign hour_inc = min_carry | (adj_inc && state == ADJ_HOUR);

    bcd_field_counter #(.MIN_BCD(8'h00), .MAX_BCD(8'h59), .RST_BCD(8'h00)) u_sec (
        .CP_1KHz(CP_1KHz), ._CR(_CR), .inc(sec_inc), .carry_en(tick),
        .value(sec), .carry(sec_carry)
    );

    bcd_field_counter #(.MIN_BCD(8'h00), .MAX_BCD(8'h59), .RST_BCD(8'h00)) u_min (
        .CP_1KHz(CP_1KHz), ._CR(_CR), .inc(min_inc), .carry_en(tick),
        .value(min), .carry(min_carry)
    );

    bcd_field_counter #(.MIN_BCD(HOUR_MIN), .MAX_BCD(HOUR_MAX), .RST_BCD(HOUR_RST)) u_hour (
        .CP_1KHz(CP_1KHz), ._CR(_CR), .inc(hour_inc), .carry_en(1'b0),
        .value(hour), .carry(hour_carry_unused)
    );

`ifdef TIME_KEEPER_12H_EN
    logic pm;

    // 11 -> 12 flips am/pm whether reached by carry or by adjust
    always_ff @(posedge CP_1KHz or negedge _CR) begin
        if (!_CR)
            pm <= 1'b0;
        else if (hour_inc && hour == 8'h11)
            pm <= ~pm;
    end

    assign dp_n = ~pm;
`else
    assign dp_n = 1'b1;
`endif

    always_ff @(posedge CP_1KHz or negedge _CR) begin
        if (!_CR)
            display_time <= DISP_RST;
        else
            display_time <= {bcd_to_seg(hour[7:4]), bcd_to_seg(hour[3:0]), SEG_DASH,
                             bcd_to_seg(min[7:4]),  bcd_to_seg(min[3:0]),  SEG_DASH,
                             bcd_to_seg(sec[7:4]),
                             bcd_to_seg(sec[3:0]) & {dp_n, 7'h7F}};
    end

endmodule

// File: tb/tb_time_keeper.sv
// Randomized self-checking bench for time_keeper; the reference model keeps
// time as seconds-of-day and renders the expected segment image from it.
module tb_time_keeper;

    localparam int TPS = 4;
    localparam logic [7:0] SEGT [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                         8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
`ifdef TIME_KEEPER_12H_EN
    localparam logic [63:0] IMG_RST = 64'hF9A4_BFC0_C0BF_C0C0;
    localparam logic [63:0] IMG_1M  = 64'hF9A4_BFC0_F9BF_C0C0;
`else
    localparam logic [63:0] IMG_RST = 64'hC0C0_BFC0_C0BF_C0C0;
    localparam logic [63:0] IMG_1M  = 64'hC0C0_BFC0_F9BF_C0C0;
`endif

    logic        CP_1KHz = 1'b0;
    logic        _CR = 1'b0;
    logic        key_mode = 1'b0;
    logic        key_inc = 1'b0;
    logic [63:0] display_time;
    logic [3:0]  index;
    logic        adjust;
    logic        sec_tick;

    int checks = 0;
    int failures = 0;

    // reference model state
    int          m_t, m_mode, m_presc;
    bit          m_h1m, m_h2m, m_h1i, m_h2i;
    logic [63:0] m_disp;
    int          tick_bad, tick_seen, tick_adj;

    time_keeper #(.TICKS_PER_SEC(TPS)) dut (
        .CP_1KHz(CP_1KHz), ._CR(_CR), .key_mode(key_mode), .key_inc(key_inc),
        .display_time(display_time), .index(index), .adjust(adjust), .sec_tick(sec_tick)
    );

    always #5 CP_1KHz = ~CP_1KHz;

    function automatic logic [63:0] img(input int t);
        int h, m, s, hd;
        logic [7:0] dp;
        h = t / 3600; m = (t / 60) % 60; s = t % 60; hd = h; dp = 8'hFF;
`ifdef TIME_KEEPER_12H_EN
        hd = (h % 12 == 0) ? 12 : h % 12;
        if (h >= 12) dp = 8'h7F;
`endif
        return {SEGT[hd/10], SEGT[hd%10], 8'hBF, SEGT[m/10], SEGT[m%10], 8'hBF,
                SEGT[s/10], SEGT[s%10] & dp};
    endfunction

    function automatic logic [3:0] exp_index(input int md);
        return (md == 2) ? 4'd3 : (md == 3) ? 4'd6 : 4'd0;
    endfunction

    task automatic model_reset();
        m_t = 0; m_mode = 0; m_presc = 0;
        m_h1m = 1; m_h2m = 1; m_h1i = 1; m_h2i = 1;
        m_disp = img(0);
    endtask

    task automatic model_edge(input bit km, input bit ki);
        bit tick, me, ie;
        int old_mode, h, mi, s;
        tick = (m_mode == 0) && (m_presc == TPS - 1);
        me = m_h1m & ~m_h2m;
        ie = m_h1i & ~m_h2i;
        m_disp = img(m_t);
        old_mode = m_mode;
        if (tick) m_t = (m_t + 1) % 86400;
        if (me) begin
            m_mode = (m_mode + 1) % 4;
        end else if (ie && m_mode != 0) begin
            h = m_t / 3600; mi = (m_t / 60) % 60; s = m_t % 60;
            if (m_mode == 1) h = (h + 1) % 24;
            if (m_mode == 2) mi = (mi + 1) % 60;
            if (m_mode == 3) s = (s + 1) % 60;
            m_t = h * 3600 + mi * 60 + s;
        end
        m_presc = (old_mode == 0 && !tick) ? m_presc + 1 : 0;
        m_h2m = m_h1m; m_h1m = km;
        m_h2i = m_h1i; m_h1i = ki;
    endtask

    // Called at a falling edge; drives keys for the next rising edge.
    task automatic step(input bit km, input bit ki);
        bit exp_t;
        key_mode = km; key_inc = ki;
        #1;
        exp_t = (m_mode == 0) && (m_presc == TPS - 1);
        if (sec_tick !== exp_t) tick_bad++;
        if (sec_tick === 1'b1) tick_seen++;
        if (sec_tick === 1'b1 && adjust === 1'b1) tick_adj++;
        @(posedge CP_1KHz);
        model_edge(km, ki);
        @(negedge CP_1KHz);
    endtask

    task automatic press_mode();
        step(1, 0); step(0, 0);
    endtask

    task automatic press_inc();
        step(0, 1); step(0, 0);
    endtask

    task automatic test_reset();
        _CR = 1'b0;
        repeat (3) @(negedge CP_1KHz);
        model_reset();
        checks++;
        if (display_time !== IMG_RST) begin failures++;
            $display("FAIL reset_display got=%h exp=%h", display_time, IMG_RST); end
        checks++;
        if (adjust !== 1'b0 || index !== 4'd0 || sec_tick !== 1'b0) begin failures++;
            $display("FAIL reset_ctl got adj=%b idx=%0d tick=%b exp 0/0/0", adjust, index, sec_tick); end
        _CR = 1'b1;
    endtask

    task automatic test_run();
        int prev, spacing_bad;
        tick_bad = 0; tick_seen = 0; spacing_bad = 0;
        for (int i = 0; i < 241; i++) begin
            prev = tick_seen;
            step(0, 0);
            if (tick_seen != prev && (i + 1) % TPS != 0) spacing_bad++;
        end
        checks++;
        if (tick_bad !== 0 || spacing_bad !== 0 || tick_seen !== 60) begin failures++;
            $display("FAIL run_ticks got bad=%0d spacing=%0d seen=%0d exp 0/0/60", tick_bad, spacing_bad, tick_seen); end
        checks++;
        if (display_time !== IMG_1M || display_time !== m_disp) begin failures++;
            $display("FAIL run_display got=%h exp=%h", display_time, IMG_1M); end
    endtask

    task automatic test_rollover(input int hour_tgt, input logic [63:0] exp_img);
        int waited;
        tick_bad = 0;
        press_mode();
        for (int i = 0; i < 24 && (m_t / 3600) != hour_tgt; i++) press_inc();
        press_mode();
        for (int i = 0; i < 60 && ((m_t / 60) % 60) != 59; i++) press_inc();
        press_mode();
        for (int i = 0; i < 60 && (m_t % 60) != 59; i++) press_inc();
        step(0, 0);
        checks++;
        if (display_time !== m_disp || adjust !== 1'b1 || index !== 4'd6) begin failures++;
            $display("FAIL adj_set got=%h adj=%b idx=%0d exp=%h adj=1 idx=6", display_time, adjust, index, m_disp); end
        press_mode();
        waited = 0;
        tick_seen = 0;
        while (tick_seen == 0 && waited < 10) begin step(0, 0); waited++; end
        checks++;
        if (waited !== TPS) begin failures++;
            $display("FAIL first_tick_latency got=%0d exp=%0d", waited, TPS); end
        step(0, 0);
        checks++;
        if (display_time !== exp_img || display_time !== m_disp || adjust !== 1'b0) begin failures++;
            $display("FAIL rollover_h%0d got=%h adj=%b exp=%h adj=0", hour_tgt, display_time, adjust, exp_img); end
        checks++;
        if (tick_bad !== 0) begin failures++;
            $display("FAIL rollover_ticks got bad=%0d exp=0", tick_bad); end
    endtask

    task automatic test_hour_wrap();
        tick_bad = 0; tick_adj = 0;
        press_mode();
        checks++;
        if (adjust !== 1'b1 || index !== 4'd0) begin failures++;
            $display("FAIL hour_mode got adj=%b idx=%0d exp 1/0", adjust, index); end
        repeat (25) press_inc();
        step(0, 0);
        checks++;
        if (display_time !== m_disp || display_time[63:48] !== 16'hC0F9) begin failures++;
            $display("FAIL hour_wrap got=%h exp=%h", display_time, m_disp); end
        checks++;
        if (tick_adj !== 0 || tick_bad !== 0) begin failures++;
            $display("FAIL adj_no_tick got adj_ticks=%0d bad=%0d exp 0/0", tick_adj, tick_bad); end
        repeat (3) press_mode();
        checks++;
        if (adjust !== 1'b0) begin failures++;
            $display("FAIL back_to_run got adj=%b exp 0", adjust); end
    endtask

    task automatic test_simul_and_reset();
        step(1, 1); step(0, 0); step(0, 0);
        checks++;
        if (adjust !== 1'b1 || index !== 4'd0 || display_time !== m_disp) begin failures++;
            $display("FAIL mode_beats_inc got adj=%b idx=%0d disp=%h exp adj=1 idx=0 disp=%h",
                     adjust, index, display_time, m_disp); end
        press_mode();
        checks++;
        if (index !== 4'd3 || adjust !== 1'b1) begin failures++;
            $display("FAIL adj_min_idx got adj=%b idx=%0d exp 1/3", adjust, index); end
        key_mode = 1'b1;
        #2 _CR = 1'b0;
        #1;
        checks++;
        if (display_time !== IMG_RST || adjust !== 1'b0 || index !== 4'd0) begin failures++;
            $display("FAIL async_reset got=%h adj=%b idx=%0d exp=%h adj=0", display_time, adjust, index, IMG_RST); end
        repeat (2) @(negedge CP_1KHz);
        model_reset();
        _CR = 1'b1;
        repeat (4) step(1, 0);
        step(0, 0);
        checks++;
        if (adjust !== 1'b0 || display_time !== m_disp) begin failures++;
            $display("FAIL held_key_release got adj=%b disp=%h exp adj=0 disp=%h", adjust, display_time, m_disp); end
    endtask

    task automatic test_random();
        int bad;
        bit km, ki;
        bad = 0; tick_bad = 0;
        for (int i = 0; i < 600; i++) begin
            km = ($urandom_range(0, 6) == 0);
            ki = ($urandom_range(0, 2) == 0);
            step(km, ki);
            if (display_time !== m_disp || adjust !== (m_mode != 0) ||
                (m_mode != 0 && index !== exp_index(m_mode))) begin
                if (bad == 0)
                    $display("FAIL random_step%0d got=%h adj=%b idx=%0d exp=%h mode=%0d",
                             i, display_time, adjust, index, m_disp, m_mode);
                bad++;
            end
        end
        checks++;
        if (bad !== 0 || tick_bad !== 0) begin failures++;
            $display("FAIL random_summary got bad=%0d tick_bad=%0d exp 0/0", bad, tick_bad); end
    endtask

    initial begin
        test_reset();
        test_run();
`ifdef TIME_KEEPER_12H_EN
        test_rollover(23, 64'hF9A4_BFC0_C0BF_C0C0);
`else
        test_rollover(23, 64'hC0C0_BFC0_C0BF_C0C0);
`endif
        test_hour_wrap();
        test_simul_and_reset();
`ifdef TIME_KEEPER_12H_EN
        test_rollover(11, 64'hF9A4_BFC0_C0BF_C040);
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
